// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared widths and FSM state encoding for the
// program loader; widths match the RAM and control unit parameters.
package program_loader_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_BYTE_W = 8;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_HDR_ADDR = 3'd1;
   localparam logic [2:0] S_HDR_LEN  = 3'd2;
   localparam logic [2:0] S_PAYLOAD  = 3'd3;
   localparam logic [2:0] S_WRITE    = 3'd4;
   localparam logic [2:0] S_CHECK    = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;
   localparam logic [2:0] S_ERROR    = 3'd7;

   function automatic int cnt_w(input int bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

endpackage

// File: rtl/program_loader_word_packer.sv
// program_loader_word_packer: assembles little-endian words from bytes.
// Ports: clk, reset_n, clr, in_data/in_valid/in_ready -> word_valid, word.
module program_loader_word_packer
   import program_loader_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BYTE_W = DEF_BYTE_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_ready,
   output logic              word_valid,
   output logic [DATA_W-1:0] word
);

   localparam int BPW   = DATA_W / BYTE_W;
   localparam int CNT_W = cnt_w(BPW);

   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] sreg;
   logic [DATA_W-1:0] snext;
   logic              accept;
   logic              last;

   assign accept = in_valid & in_ready;
   assign last   = (cnt == CNT_W'(BPW - 1));

   // New byte enters at the top and older bytes shift down, so after
   // BPW bytes the first one sits in the low lane.
   assign snext = {in_data, sreg[DATA_W-1:BYTE_W]};

   // The completed word is presented combinationally so the FSM can act
   // on the same edge that accepts the final byte.
   assign word_valid = accept & last;
   assign word       = snext;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (clr) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (accept) begin
         sreg <= snext;
         cnt  <= last ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/program_loader.sv
// program_loader: streams a framed program image into RAM, checks the
// checksum and hands the bus to the control unit. Ports: clk, reset_n,
// start, in_data/in_valid/in_ready, ram_*, bus_owner, cu_enable, error.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int BYTE_W = DEF_BYTE_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_write,
   output logic              ram_read,
   output logic              bus_owner,
   output logic              cu_enable,
   output logic              error
);

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] acc;
   logic              word_valid;
   logic [DATA_W-1:0] word;
   logic              start_ok;

   assign start_ok = start & ((state == S_IDLE) |
                              (state == S_DONE) |
                              (state == S_ERROR));

   program_loader_word_packer #(
      .DATA_W (DATA_W),
      .BYTE_W (BYTE_W)
   ) u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (start_ok),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .word_valid (word_valid),
      .word       (word)
   );

   always_comb begin
      in_ready  = 1'b0;
      bus_owner = 1'b0;
      unique case (1'b1)
         (state == S_HDR_ADDR),
         (state == S_HDR_LEN),
         (state == S_PAYLOAD),
         (state == S_CHECK): begin
            in_ready  = 1'b1;
            bus_owner = 1'b1;
         end
         (state == S_WRITE): bus_owner = 1'b1;
         default: ;
      endcase
   end

   assign ram_write = (state == S_WRITE);
   assign ram_read  = 1'b0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         addr      <= '0;
         rem       <= '0;
         acc       <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cu_enable <= 1'b0;
         error     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               acc       <= '0;
               error     <= 1'b0;
               cu_enable <= 1'b0;
               if (start) state <= S_HDR_ADDR;
            end
            S_HDR_ADDR: begin
               if (word_valid) begin
                  addr  <= word[ADDR_W-1:0];
                  state <= S_HDR_LEN;
               end
            end
            S_HDR_LEN: begin
               if (word_valid) begin
                  rem   <= word;
                  state <= (word != '0) ? S_PAYLOAD : S_CHECK;
               end
            end
            S_PAYLOAD: begin
               // Bus outputs only move here, so they hold between strobes.
               if (word_valid) begin
                  ram_addr  <= addr;
                  ram_wdata <= word;
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               acc   <= acc + ram_wdata;
               addr  <= addr + ADDR_W'(1);
               rem   <= rem - DATA_W'(1);
               state <= (rem > DATA_W'(1)) ? S_PAYLOAD : S_CHECK;
            end
            S_CHECK: begin
               if (word_valid) begin
                  if (word == acc) begin
                     cu_enable <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     error <= 1'b1;
                     state <= S_ERROR;
                  end
               end
            end
            S_DONE, S_ERROR: begin
               if (start) begin
                  acc       <= '0;
                  error     <= 1'b0;
                  cu_enable <= 1'b0;
                  state     <= S_HDR_ADDR;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
